// File: rtl/prbs_checker_if.sv
// Bit-stream and status bundle of the PRBS checker.
// master drives the received stream, slave is the checker.
interface prbs_checker_if #(
    parameter int WIDTH = 5,
    parameter int ERR_W = 16,
    parameter int CNT_W = 32
);
    logic             en_i;
    logic             bit_i;
    logic [WIDTH-1:0] polynom_i;
    logic             clr_i;
    logic             locked_o;
    logic             err_o;
    logic [ERR_W-1:0] err_cnt_o;
    logic [CNT_W-1:0] bit_cnt_o;

    modport master (
        output en_i, bit_i, polynom_i, clr_i,
        input  locked_o, err_o, err_cnt_o, bit_cnt_o
    );

    modport slave (
        input  en_i, bit_i, polynom_i, clr_i,
        output locked_o, err_o, err_cnt_o, bit_cnt_o
    );
endinterface

// File: rtl/prbs_checker.sv
// Self-synchronising LFSR stream checker.
// Acquires, verifies, then free-runs its reference and counts bit errors.
module prbs_checker #(
    parameter int WIDTH      = 5,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4,
    parameter int ERR_W      = 16,
    parameter int CNT_W      = 32
) (
    input logic         clk,
    input logic         rst,
    prbs_checker_if.slave bus
);
    localparam int FW = $clog2(WIDTH + 1);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int XW = $clog2(UNLOCK_CNT + 1);

    typedef enum logic [1:0] {
        ACQUIRE,
        VERIFY,
        LOCKED
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sh_q;
    logic [FW-1:0]    fill_q;
    logic [MW-1:0]    match_q;
    logic [XW-1:0]    miss_q;
    logic             locked_q;
    logic             err_q;
    logic [ERR_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] bit_cnt_q;

    logic             pred;
    logic             mis;
    logic             in_bit;
    logic [WIDTH-1:0] sh_d;
    logic [FW-1:0]    fill_d;

    always_comb begin
        pred = sh_q[0];
        for (int i = 1; i < WIDTH; i++) begin
            pred = pred ^ (bus.polynom_i[WIDTH-1-i] & sh_q[i]);
        end
        mis    = bus.bit_i ^ pred;
        // Once locked the reference free-runs, so one bad bit is one error.
        in_bit = (state_q == LOCKED) ? pred : bus.bit_i;
        sh_d   = {in_bit, sh_q[WIDTH-1:1]};
        fill_d = (fill_q == FW'(WIDTH)) ? fill_q : fill_q + FW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clr_i) begin
            state_q   <= ACQUIRE;
            fill_q    <= '0;
            match_q   <= '0;
            miss_q    <= '0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            bit_cnt_q <= '0;
            if (rst) begin
                sh_q <= '0;
            end
        end else begin
            err_q <= 1'b0;
            if (bus.en_i) begin
                sh_q <= sh_d;
                unique case (state_q)
                    ACQUIRE: begin
                        fill_q <= fill_d;
                        if (fill_d == FW'(WIDTH) && sh_d != '0) begin
                            state_q <= VERIFY;
                            match_q <= '0;
                        end
                    end
                    VERIFY: begin
                        if (!mis) begin
                            if (match_q == MW'(LOCK_CNT - 1)) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                                miss_q   <= '0;
                            end else begin
                                match_q <= match_q + MW'(1);
                            end
                        end else begin
                            state_q <= ACQUIRE;
                            fill_q  <= '0;
                        end
                    end
                    LOCKED: begin
                        if (bit_cnt_q != '1) begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                        if (mis) begin
                            err_q <= 1'b1;
                            if (err_cnt_q != '1) begin
                                err_cnt_q <= err_cnt_q + ERR_W'(1);
                            end
                            if (miss_q == XW'(UNLOCK_CNT - 1)) begin
                                state_q  <= ACQUIRE;
                                locked_q <= 1'b0;
                                fill_q   <= '0;
                            end else begin
                                miss_q <= miss_q + XW'(1);
                            end
                        end else begin
                            miss_q <= '0;
                        end
                    end
                    default: begin
                        state_q  <= ACQUIRE;
                        locked_q <= 1'b0;
                        fill_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.locked_o  = locked_q;
    assign bus.err_o     = err_q;
    assign bus.err_cnt_o = err_cnt_q;
    assign bus.bit_cnt_o = bit_cnt_q;
endmodule

// File: doc/prbs_checker.md
# prbs_checker

Serial receiver-side counterpart of the TRNG LFSR generator. It takes the generator's bit stream one bit per enabled cycle and self-synchronises a local reference LFSR to it, using the same polynomial encoding. Once locked, it counts bit errors and checked bits for the health-test and bring-up logic. It sits after the serialised LFSR output, or after an external loopback, and is read by the control/status block.

## Interface
- WIDTH, 5: LFSR length; must match the generator.
- LOCK_CNT, 8: consecutive matching bits required to declare lock (≥1).
- UNLOCK_CNT, 4: consecutive mismatches in LOCKED that drop lock (≥1).
- ERR_W, 16: error counter width.
- CNT_W, 32: checked-bit counter width.

- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- en_i  in  1  bit_i valid this cycle.
- bit_i  in  1  received serial bit (generator register bit 0 per step).
- polynom_i  in  WIDTH  tap vector; same encoding as the generator; static while running.
- clr_i  in  1  clears counters and restarts acquisition.
- locked_o  out  1  high while in LOCKED.
- err_o  out  1  one-cycle pulse per counted error.
- err_cnt_o  out  ERR_W  saturating error count.
- bit_cnt_o  out  CNT_W  saturating count of bits checked while LOCKED.

## Operation
- Shadow register sh[WIDTH-1:0] mirrors the generator: each enabled step, sh <= {in_bit, sh[WIDTH-1:1]}.
- Predicted bit pred = sh[0] XOR (XOR over i=1..WIDTH-1 of polynom_i[WIDTH-1-i] & sh[i]). This equals the generator's next feedback, so the stream satisfies s[n+WIDTH] = pred.
- FSM states: ACQUIRE, VERIFY, LOCKED. Nothing changes on cycles with en_i=0.
- ACQUIRE:
  - in_bit = bit_i; fill_cnt increments, saturating at WIDTH.
  - When the shift makes fill_cnt = WIDTH and the new sh ≠ 0, go to VERIFY with match_cnt = 0.
  - An all-zero sh keeps the block in ACQUIRE and keeps it shifting.
- VERIFY:
  - in_bit = bit_i.
  - On bit_i == pred, match_cnt increments; on the LOCK_CNT-th match, go to LOCKED with miss_cnt = 0.
  - On mismatch, go to ACQUIRE with fill_cnt = 0. sh still shifts bit_i in.
  - No counters change in VERIFY.
- LOCKED:
  - in_bit = pred, so the reference free-runs and one corrupted bit counts exactly one error.
  - Each enabled bit increments bit_cnt (saturating at all-ones).
  - On mismatch: err_cnt increments (saturating), err_o pulses, miss_cnt increments.
  - On match: miss_cnt = 0.
  - When miss_cnt reaches UNLOCK_CNT, go to ACQUIRE with fill_cnt = 0. Counters are kept.
- clr_i:
  - Zeroes err_cnt, bit_cnt, fill_cnt, match_cnt and miss_cnt, sets state ACQUIRE and forces err_o = 0. sh is unchanged.
  - Overrides a simultaneous en_i; that bit is discarded.
- rst: same as clr_i, and also sets sh = 0.
- Reset values of outputs: locked_o = 0, err_o = 0, err_cnt_o = 0, bit_cnt_o = 0.
- Both counters saturate; they never wrap.

## Timing
- All outputs are registered. Each reflects the en_i sample from the previous cycle.
- Lock latency from ACQUIRE with a clean stream: WIDTH + LOCK_CNT enabled bits. locked_o rises on the cycle after the last of those bits is sampled.
- err_o is high exactly one cycle, the cycle after the mismatching sample, and only in LOCKED. err_cnt_o updates on the same edge.
- locked_o falls on the cycle after the UNLOCK_CNT-th consecutive mismatch is sampled. err_o still pulses for that mismatch.
- en_i may be sparse or bursty; gaps hold all state.
- A polynom_i change must be followed by clr_i; without it, behaviour is undefined until reacquire.

## Test plan
- Reset with en_i=0 for 10 cycles -> locked_o=0, err_o=0, err_cnt_o=0, bit_cnt_o=0.
- WIDTH=5, polynom_i=5'b00100, generator seeded 5'b00001, en_i every cycle -> locked_o high the cycle after the 13th bit; after 100 more bits, err_cnt_o=0 and bit_cnt_o=100.
- Same setup, en_i toggling 1/0 -> lock after 13 enabled bits (26 cycles); counts unaffected by the gaps.
- Once locked, flip one bit -> one err_o pulse, err_cnt_o=1, locked_o stays 1. Flip 4 consecutive bits -> err_cnt_o=5, locked_o drops the cycle after the 4th. With a clean stream afterwards -> relock 13 bits later, err_cnt_o still 5.
- All-zero stream for 200 bits -> locked_o stays 0; err_cnt_o and bit_cnt_o stay 0.
- ERR_W=4, locked, 20 isolated single-bit flips spaced ≥8 bits apart -> err_cnt_o saturates at 15. Then clr_i together with en_i -> all counters 0, locked_o=0 the next cycle, that bit ignored, relock after 13 further bits.
